// File: rtl/piso_shift_transmitter.sv
// piso_shift_transmitter: takes a parallel word over a valid/ready handshake and sends it MSB-first, one bit per clock.
// frameActive marks each valid bit; pause stretches the current bit; done pulses for one cycle after the last bit.
`default_nettype none

module piso_shift_transmitter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  input  logic             pause,
  output logic             serialOutput,
  output logic             frameActive,
  output logic [CNT_W-1:0] bitCount,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               done_q,  done_d;

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dataValid) begin
          shreg_d = dataIn;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // While paused everything holds, stretching the bit currently on the line.
        if (!pause) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dataReady    = (state_q == IDLE) && !clear;
  assign frameActive  = (state_q == SHIFT);
  assign serialOutput = frameActive & shreg_q[WIDTH-1];
  assign bitCount     = cnt_q;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_transmitter.sv
// Self-checking bench for piso_shift_transmitter: directed scenarios plus randomized traffic against a bit-index model.
`default_nettype none

module tb_piso_shift_transmitter;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  dataIn = '0;
  logic          dataValid = 1'b0;
  logic          pause = 1'b0;
  logic          dataReady, serialOutput, frameActive, done;
  logic [CW-1:0] bitCount;

  int checks = 0;
  int failures = 0;

  piso_shift_transmitter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clockpulse  (clk),
    .clear       (clear),
    .dataIn      (dataIn),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .pause       (pause),
    .serialOutput(serialOutput),
    .frameActive (frameActive),
    .bitCount    (bitCount),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference: which word is in flight and how many of its bits are already sent.
  logic         m_busy, m_done;
  logic [W-1:0] m_word;
  int           m_sent;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_word <= '0; m_sent <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (dataValid) begin m_busy <= 1'b1; m_word <= dataIn; m_sent <= 0; end
      end else if (!pause) begin
        if (m_sent == W - 1) begin m_busy <= 1'b0; m_sent <= 0; m_done <= 1'b1; end
        else m_sent <= m_sent + 1;
      end
    end
  end

  // Companion receiver: shifts in serial bits while frameActive and not paused.
  logic [W-1:0] rx;
  always @(posedge clk or posedge clear) begin
    if (clear) rx <= '0;
    else if (frameActive && !pause) rx <= {rx[W-2:0], serialOutput};
  end

  function automatic logic [CW+3:0] exp_vec();
    logic s;
    s = m_busy ? m_word[W-1-m_sent] : 1'b0;
    return {(!m_busy && !clear), s, m_busy, m_done, CW'(m_sent)};
  endfunction

  logic [CW+3:0] act_vec;
  assign act_vec = {dataReady, serialOutput, frameActive, done, bitCount};

  bit ser_q[$];
  int cnt_hist[$];
  int done_n;

  task automatic clear_obs();
    ser_q.delete(); cnt_hist.delete(); done_n = 0;
  endtask

  task automatic observe();
    if (frameActive) begin ser_q.push_back(serialOutput); cnt_hist.push_back(int'(bitCount)); end
    if (done) done_n++;
  endtask

  function automatic logic [31:0] pack_bits();
    logic [31:0] v = '0;
    foreach (ser_q[i]) v = {v[30:0], ser_q[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_cnts();
    logic [31:0] v = '0;
    foreach (cnt_hist[i]) v = {v[27:0], cnt_hist[i][3:0]};
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (act_vec !== '0) begin failures++; $display("FAIL reset_hold outputs got=%b exp=%b", act_vec, {(CW+4){1'b0}}); end
    clear = 1'b0;
    #1;
    checks++;
    if (dataReady !== 1'b1) begin failures++; $display("FAIL reset_release dataReady got=%b exp=1", dataReady); end
    @(negedge clk);
    checks++;
    if (act_vec !== exp_vec()) begin failures++; $display("FAIL reset_idle vec got=%b exp=%b", act_vec, exp_vec()); end
    dataValid = 1'b1; dataIn = 4'b1111;
    #2 clear = 1'b1;
    #1;
    checks++;
    if (act_vec !== '0) begin failures++; $display("FAIL reset_midcycle outputs got=%b exp=%b", act_vec, {(CW+4){1'b0}}); end
    @(posedge clk); #1;
    checks++;
    if (act_vec !== '0) begin failures++; $display("FAIL reset_edge outputs got=%b exp=%b", act_vec, {(CW+4){1'b0}}); end
    dataValid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (act_vec !== {1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
      failures++; $display("FAIL reset_after outputs got=%b exp=%b", act_vec, {1'b1, {(CW+3){1'b0}}});
    end
  endtask

  task automatic test_single_frame();
    clear_obs();
    dataIn = 4'b1011; dataValid = 1'b1;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL single cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      observe();
      if (n == 0) begin dataValid = 1'b0; dataIn = 4'b0100; end
    end
    checks++;
    if (ser_q.size() != 4 || pack_bits() !== 32'b1011) begin failures++; $display("FAIL single serial got=%b n=%0d exp=1011", pack_bits(), ser_q.size()); end
    checks++;
    if (pack_cnts() !== 32'h0123) begin failures++; $display("FAIL single bitCount got=%h exp=0123", pack_cnts()); end
    checks++;
    if (done_n != 1) begin failures++; $display("FAIL single done_pulses got=%0d exp=1", done_n); end
    checks++;
    if (rx !== 4'b1011) begin failures++; $display("FAIL single rx got=%b exp=1011", rx); end
  endtask

  task automatic test_pause();
    clear_obs();
    dataIn = 4'b1100; dataValid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL pause cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      observe();
      if (n == 0) dataValid = 1'b0;
      pause = (n >= 1 && n <= 3);
    end
    pause = 1'b0;
    checks++;
    if (ser_q.size() != 7 || pack_bits() !== 32'b1111100) begin failures++; $display("FAIL pause serial got=%b n=%0d exp=1111100", pack_bits(), ser_q.size()); end
    checks++;
    if (pack_cnts() !== 32'h0111123) begin failures++; $display("FAIL pause bitCount got=%h exp=0111123", pack_cnts()); end
    checks++;
    if (done_n != 1 || rx !== 4'b1100) begin failures++; $display("FAIL pause result done=%0d rx=%b exp done=1 rx=1100", done_n, rx); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    dataIn = 4'b0110; dataValid = 1'b1;
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL b2b cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      if (n == 4) begin
        checks++;
        if (!(done === 1'b1 && dataReady === 1'b1 && frameActive === 1'b0)) begin
          failures++; $display("FAIL b2b gap done=%b ready=%b active=%b exp 1 1 0", done, dataReady, frameActive);
        end
      end
      observe();
      if (n == 0) dataIn = 4'b1001;
      if (n == 5) dataValid = 1'b0;
    end
    checks++;
    if (ser_q.size() != 8 || pack_bits() !== 32'b01101001) begin failures++; $display("FAIL b2b serial got=%b n=%0d exp=01101001", pack_bits(), ser_q.size()); end
    checks++;
    if (pack_cnts() !== 32'h01230123 || done_n != 2) begin failures++; $display("FAIL b2b counts got=%h done=%0d exp=01230123 done=2", pack_cnts(), done_n); end
  endtask

  task automatic test_ignore_busy();
    clear_obs();
    dataIn = 4'b0001; dataValid = 1'b1;
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL busy cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      if (n < 4) begin
        checks++;
        if (dataReady !== 1'b0) begin failures++; $display("FAIL busy ready cyc%0d got=%b exp=0", n, dataReady); end
      end
      observe();
      if (n == 0) dataIn = 4'b1111;
      if (n == 5) dataValid = 1'b0;
    end
    checks++;
    if (ser_q.size() != 8 || pack_bits() !== 32'b00011111) begin failures++; $display("FAIL busy serial got=%b n=%0d exp=00011111", pack_bits(), ser_q.size()); end
  endtask

  task automatic test_abort();
    clear_obs();
    dataIn = 4'b1010; dataValid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL abort cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      observe();
      dataValid = 1'b0;
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (act_vec !== '0) begin failures++; $display("FAIL abort outputs got=%b exp=%b", act_vec, {(CW+4){1'b0}}); end
    @(negedge clk);
    clear = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL abort_after cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      observe();
    end
    checks++;
    if (done_n != 0) begin failures++; $display("FAIL abort done_pulses got=%0d exp=0", done_n); end
    clear_obs();
    dataIn = 4'b0101; dataValid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL resend cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      observe();
      dataValid = 1'b0;
    end
    checks++;
    if (ser_q.size() != 4 || pack_bits() !== 32'b0101 || done_n != 1 || rx !== 4'b0101) begin
      failures++; $display("FAIL resend result serial=%b done=%0d rx=%b exp serial=0101 done=1 rx=0101", pack_bits(), done_n, rx);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin failures++; $display("FAIL random cyc%0d vec got=%b exp=%b", n, act_vec, exp_vec()); end
      if (m_done) begin
        checks++;
        if (rx !== m_word) begin failures++; $display("FAIL random rx cyc%0d got=%b exp=%b", n, rx, m_word); end
      end
      dataIn    = W'($urandom);
      dataValid = ($urandom_range(0, 2) != 0);
      pause     = ($urandom_range(0, 3) == 0);
    end
    dataValid = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #1 clear = 1'b1;
    test_reset();
    test_single_frame();
    test_pause();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
